// File: rtl/rv_ctl.sv
// rv_ctl: multicycle control unit for the simple RISC-V core.
// Decodes the datapath's registered instruction (instr) and ALU zero flag and
// drives every datapath enable and mux select plus the data-memory write strobe.
// Also keeps a retired-instruction counter and a sticky unsupported-opcode flag.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   instr, zero      IR contents and combinational ALU-result-is-zero flag
//   pcsourse/pcwrite PC next-value select and load enable
//   pccen, irwrite   PCC capture and IR load enables
//   wbsel, regwen    register write-back select and write enable
//   immsel           immediate format select
//   asel, bsel       ALU operand selects
//   alusel           ALU operation code
//   ALUouten         ALUOUT load enable
//   DATAwsel         store data select
//   mdrwrite         MDR load enable
//   dmem_we          data-memory write strobe
//   illegal          sticky unsupported-opcode flag (held until reset)
//   instr_done       one-cycle pulse on an instruction's last cycle
//   instret          retired-instruction count
module rv_ctl #(
    parameter int unsigned DPWIDTH  = 32,
    parameter int unsigned CNTWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DPWIDTH-1:0]  instr,
    input  logic                zero,
    output logic                pcsourse,
    output logic                pcwrite,
    output logic                pccen,
    output logic                irwrite,
    output logic [1:0]          wbsel,
    output logic                regwen,
    output logic [1:0]          immsel,
    output logic [1:0]          asel,
    output logic [1:0]          bsel,
    output logic [3:0]          alusel,
    output logic                ALUouten,
    output logic                DATAwsel,
    output logic                mdrwrite,
    output logic                dmem_we,
    output logic                illegal,
    output logic                instr_done,
    output logic [CNTWIDTH-1:0] instret
);

    // Datapath encodings
    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd0;
    localparam logic [1:0] IMM_B     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd3;
    localparam logic [1:0] ALUA_PCC  = 2'd0;
    localparam logic [1:0] ALUA_REG  = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd0;
    localparam logic [1:0] ALUB_REG  = 2'd1;
    localparam logic       DATA_B    = 1'b1;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAddr,
        StMemRd, StMemWb, StMemWr, StBranch, StJal, StIllegal
    } state_e;

    state_e state_q, state_d;
    logic [CNTWIDTH-1:0] instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    // alt selects SUB (funct3=000) or SRA (funct3=101).
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                instret_q <= instret_q + CNTWIDTH'(1);
            end
        end
    end

    assign instret = instret_q;

    always_comb begin
        state_d    = state_q;
        pcsourse   = PC_PLUS4;
        pcwrite    = 1'b0;
        pccen      = 1'b0;
        irwrite    = 1'b0;
        wbsel      = 2'd0;
        regwen     = 1'b0;
        immsel     = 2'd0;
        asel       = 2'd0;
        bsel       = 2'd0;
        alusel     = 4'd0;
        ALUouten   = 1'b0;
        DATAwsel   = 1'b0;
        mdrwrite   = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            StFetch: begin
                irwrite  = 1'b1;
                pccen    = 1'b1;
                pcwrite  = 1'b1;
                pcsourse = PC_PLUS4;
                state_d  = StDecode;
            end
            StDecode: begin
                // Speculatively compute the branch/jump target from PCC.
                asel     = ALUA_PCC;
                bsel     = ALUB_IMM;
                alusel   = ALU_ADD;
                ALUouten = 1'b1;
                immsel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_R:             state_d = StExecR;
                    OP_I:             state_d = StExecI;
                    OP_LOAD, OP_STORE: state_d = StMemAddr;
                    OP_BR:            state_d = StBranch;
                    OP_JAL:           state_d = StJal;
                    default:          state_d = StIllegal;
                endcase
            end
            StExecR: begin
                asel     = ALUA_REG;
                bsel     = ALUB_REG;
                ALUouten = 1'b1;
                alusel   = alu_op(funct3, funct7b5);
                state_d  = StAluWb;
            end
            StExecI: begin
                asel     = ALUA_REG;
                bsel     = ALUB_IMM;
                immsel   = IMM_L;
                ALUouten = 1'b1;
                // No SUBI: funct7[5] only distinguishes SRAI from SRLI.
                alusel   = alu_op(funct3, funct7b5 && (funct3 == 3'b101));
                state_d  = StAluWb;
            end
            StAluWb: begin
                wbsel      = WB_ALUOUT;
                regwen     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemAddr: begin
                asel     = ALUA_REG;
                bsel     = ALUB_IMM;
                alusel   = ALU_ADD;
                ALUouten = 1'b1;
                if (opcode == OP_LOAD) begin
                    immsel  = IMM_L;
                    state_d = StMemRd;
                end else begin
                    immsel  = IMM_S;
                    state_d = StMemWr;
                end
            end
            StMemRd: begin
                mdrwrite = 1'b1;
                state_d  = StMemWb;
            end
            StMemWb: begin
                wbsel      = WB_MDR;
                regwen     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                dmem_we    = 1'b1;
                DATAwsel   = DATA_B;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                // ALUOUT keeps the DECODE target; the SUB only feeds zero.
                asel       = ALUA_REG;
                bsel       = ALUB_REG;
                alusel     = ALU_SUB;
                pcsourse   = PC_ALU;
                pcwrite    = (funct3 == 3'b000) ? zero :
                             (funct3 == 3'b001) ? !zero : 1'b0;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                wbsel      = WB_PC;
                regwen     = 1'b1;
                pcwrite    = 1'b1;
                pcsourse   = PC_ALU;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StIllegal: begin
                illegal = 1'b1;
                state_d = StIllegal;
            end
            default: state_d = StFetch;
        endcase

        // Reset lands in FETCH; suppress its enables so nothing is written.
        if (rst) begin
            pcwrite    = 1'b0;
            pccen      = 1'b0;
            irwrite    = 1'b0;
            regwen     = 1'b0;
            ALUouten   = 1'b0;
            mdrwrite   = 1'b0;
            dmem_we    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_ctl.sv
// Bench for rv_ctl: directed instructions from the test plan followed by
// random supported instructions, each cycle compared against a per-instruction
// cycle-table model, plus the illegal-opcode hold and a mid-instruction reset.
module tb_rv_ctl;

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic [1:0] wbsel;
        logic       regwen;
        logic [1:0] immsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [3:0] alusel;
        logic       ALUouten;
        logic       DATAwsel;
        logic       mdrwrite;
        logic       dmem_we;
        logic       illegal;
        logic       instr_done;
    } ctl_t;

    // Encodings expected at the datapath interface
    localparam logic       PC_PLUS4 = 1'b0, PC_ALU = 1'b1;
    localparam logic [1:0] WB_MDR = 2'd0, WB_ALUOUT = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] IMM_J = 2'd0, IMM_B = 2'd1, IMM_S = 2'd2, IMM_L = 2'd3;
    localparam logic [1:0] A_PCC = 2'd0, A_REG = 2'd1, B_IMM = 2'd0, B_REG = 2'd1;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    localparam logic [3:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        ALUouten, DATAwsel, mdrwrite, dmem_we, illegal, instr_done;
    logic [31:0] instret;

    int          n_total;
    int          n_pass;
    logic [31:0] cnt;

    rv_ctl #(.DPWIDTH(32), .CNTWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .ALUouten(ALUouten), .DATAwsel(DATAwsel),
        .mdrwrite(mdrwrite), .dmem_we(dmem_we), .illegal(illegal),
        .instr_done(instr_done), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Total cycles an instruction occupies; unsupported opcodes get a 20-cycle
    // observation window after FETCH and DECODE.
    function automatic int latency(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0010011: return 4;
            7'b0000011:             return 5;
            7'b0100011:             return 4;
            7'b1100011, 7'b1101111: return 3;
            default:                return 22;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7,
                                           input logic is_r);
        logic [3:0] base [8];
        logic [3:0] op;
        base = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        op = base[f3];
        if (f3 == 3'd5 && f7) op = SRA;
        if (f3 == 3'd0 && f7 && is_r) op = SUB;
        return op;
    endfunction

    // Expected control word for cycle k (0 = first) of instruction ins.
    function automatic ctl_t model(input logic [31:0] ins, input int k, input logic z);
        ctl_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        int         ph;
        e   = '0;
        opc = ins[6:0];
        f3  = ins[14:12];
        ph  = k - 2;
        if (k == 0) begin
            e.irwrite = 1; e.pccen = 1; e.pcwrite = 1; e.pcsourse = PC_PLUS4;
        end else if (k == 1) begin
            e.asel = A_PCC; e.bsel = B_IMM; e.alusel = ADD; e.ALUouten = 1;
            e.immsel = (opc == 7'b1101111) ? IMM_J : IMM_B;
        end else begin
            case (opc)
                7'b0110011, 7'b0010011: begin
                    if (ph == 0) begin
                        e.asel = A_REG; e.ALUouten = 1;
                        if (opc == 7'b0110011) begin
                            e.bsel = B_REG;
                        end else begin
                            e.bsel = B_IMM; e.immsel = IMM_L;
                        end
                        e.alusel = ref_alu(f3, ins[30], opc == 7'b0110011);
                    end else begin
                        e.wbsel = WB_ALUOUT; e.regwen = 1; e.instr_done = 1;
                    end
                end
                7'b0000011, 7'b0100011: begin
                    if (ph == 0) begin
                        e.asel = A_REG; e.bsel = B_IMM; e.alusel = ADD; e.ALUouten = 1;
                        e.immsel = (opc == 7'b0000011) ? IMM_L : IMM_S;
                    end else if (opc == 7'b0100011) begin
                        e.dmem_we = 1; e.DATAwsel = 1; e.instr_done = 1;
                    end else if (ph == 1) begin
                        e.mdrwrite = 1;
                    end else begin
                        e.wbsel = WB_MDR; e.regwen = 1; e.instr_done = 1;
                    end
                end
                7'b1100011: begin
                    e.asel = A_REG; e.bsel = B_REG; e.alusel = SUB; e.pcsourse = PC_ALU;
                    e.pcwrite = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
                    e.instr_done = 1;
                end
                7'b1101111: begin
                    e.wbsel = WB_PC; e.regwen = 1; e.pcwrite = 1; e.pcsourse = PC_ALU;
                    e.instr_done = 1;
                end
                default: e.illegal = 1;
            endcase
        end
        return e;
    endfunction

    function automatic ctl_t observed();
        ctl_t o;
        o.pcsourse = pcsourse;  o.pcwrite  = pcwrite;  o.pccen    = pccen;
        o.irwrite  = irwrite;   o.wbsel    = wbsel;    o.regwen   = regwen;
        o.immsel   = immsel;    o.asel     = asel;     o.bsel     = bsel;
        o.alusel   = alusel;    o.ALUouten = ALUouten; o.DATAwsel = DATAwsel;
        o.mdrwrite = mdrwrite;  o.dmem_we  = dmem_we;  o.illegal  = illegal;
        o.instr_done = instr_done;
        return o;
    endfunction

    task automatic check_ctl(input string tag, input ctl_t exp);
        ctl_t obs;
        obs = observed();
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s ctl: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
        n_total++;
        assert (instret === exp) n_pass++;
        else $error("FAIL %s instret: observed %0d expected %0d", tag, instret, exp);
    endtask

    // Entered at a negedge with the DUT in FETCH. zmode: 0/1 fixed zero,
    // 2 random. ncyc=0 runs the full instruction and ends at the next FETCH
    // negedge; ncyc>0 stops after that many cycles without advancing.
    task automatic run_instr(input logic [31:0] ins, input int zmode, input int ncyc);
        int   n;
        ctl_t e;
        n = (ncyc > 0) ? ncyc : latency(ins);
        instr = ins;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            e = model(ins, k, zero);
            check_ctl($sformatf("%h c%0d z%0b", ins, k, zero), e);
            check_cnt($sformatf("%h c%0d", ins, k), cnt);
            if (e.instr_done) cnt++;
        end
        if (ncyc == 0) @(negedge clk);
    endtask

    // Asserts reset wherever the DUT currently is; ends at a negedge in FETCH.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        cnt = '0;
        check_ctl({tag, " during rst"}, '0);
        check_cnt({tag, " during rst"}, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0]  opcs [6];
    logic [31:0] rnd;

    initial begin
        n_total = 0;
        n_pass  = 0;
        cnt     = '0;
        rst     = 1'b1;
        instr   = '0;
        zero    = 1'b0;
        opcs    = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111};

        do_reset("power-on");

        run_instr(32'h002081B3, 2, 0);  // add
        run_instr(32'h40208233, 2, 0);  // sub
        run_instr(32'h4030D093, 2, 0);  // srai
        run_instr(32'h0080A283, 2, 0);  // lw
        run_instr(32'h0020A223, 2, 0);  // sw
        run_instr(32'h00000463, 1, 0);  // beq taken
        run_instr(32'h00000463, 0, 0);  // beq not taken
        run_instr(32'h00001463, 1, 0);  // bne not taken
        run_instr(32'h00001463, 0, 0);  // bne taken
        run_instr(32'h010000EF, 2, 0);  // jal

        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            run_instr({rnd[31:7], opcs[$urandom_range(0, 5)]}, 2, 0);
        end

        // Unsupported opcode: sticky flag, no enables, counter frozen.
        run_instr(32'h00000000, 2, 0);
        do_reset("after illegal");

        // Reset during MEM_RD of a load (cycle index 3).
        run_instr(32'h0080A283, 2, 4);
        do_reset("mid-load");
        run_instr(32'h002081B3, 2, 0);
        run_instr(32'h0020A223, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_ctl.md
Name: rv_ctl

Overview:
Multicycle control unit for the simple RISC-V core. It sits directly upstream of the datapath. It decodes the datapath's registered instruction and zero flag and drives every datapath enable and mux select, plus the data-memory write strobe. It also keeps a retired-instruction counter and flags unsupported opcodes.

Parameters:
DPWIDTH, 32, instruction width
CNTWIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr  in  DPWIDTH  IR contents from datapath
zero  in  1  datapath ALU result == 0 (combinational)
pcsourse  out  1  PC_PLUS4 / PC_ALU
pcwrite  out  1  PC load enable
pccen  out  1  PCC capture enable
irwrite  out  1  IR load enable
wbsel  out  2  WB_MDR / WB_ALUOUT / WB_PC
regwen  out  1  register-file write enable
immsel  out  2  IMM_J / IMM_B / IMM_S / IMM_L
asel  out  2  ALUA_PCC / ALUA_REG
bsel  out  2  ALUB_IMM / ALUB_REG
alusel  out  4  ALU_* operation code
ALUouten  out  1  ALUOUT load enable
DATAwsel  out  1  store data select (DATA_B)
mdrwrite  out  1  MDR load enable
dmem_we  out  1  data-memory write strobe
illegal  out  1  sticky unsupported-opcode flag
instr_done  out  1  one-cycle pulse on an instruction's last cycle
instret  out  CNTWIDTH  retired-instruction count

Behaviour:
- Encodings come from params.inc. The clock and reset are a single clock and an asynchronous active-high reset, exactly as fixed above.
- Reset: state=FETCH, instret=0, illegal=0.
- While rst is high, all enables (pcwrite, pccen, irwrite, regwen, ALUouten, mdrwrite, dmem_we, instr_done) are 0.
- Outputs are Moore, decoded from the state and instr only. The one exception is BRANCH pcwrite, which also depends on zero.
- Enables not listed for a state are 0. Selects not listed in a state are don't-care; drive them to 0.
- FETCH: irwrite=1, pccen=1, pcwrite=1, pcsourse=PC_PLUS4. Next state is DECODE.
- DECODE: asel=PCC, bsel=IMM, alusel=ADD, ALUouten=1, immsel=IMM_J if opcode is 1101111, else IMM_B. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> ILLEGAL
- EXEC_R: asel=REG, bsel=REG, ALUouten=1, alusel from funct3/funct7[5]. Next state is ALU_WB.
- EXEC_I: asel=REG, bsel=IMM, immsel=IMM_L, ALUouten=1. alusel from funct3; funct7[5] is used only when funct3=101. Next state is ALU_WB.
- ALU op mapping (funct3):
  - 000: ADD; SUB when R-type and funct7[5]=1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when funct7[5]=1
  - 110: OR
  - 111: AND
- ALU_WB: wbsel=WB_ALUOUT, regwen=1, instr_done=1. Next state is FETCH.
- MEM_ADDR: asel=REG, bsel=IMM, alusel=ADD, ALUouten=1. immsel=IMM_L for a load, IMM_S for a store. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mdrwrite=1. Next state is MEM_WB.
- MEM_WB: wbsel=WB_MDR, regwen=1, instr_done=1. Next state is FETCH.
- MEM_WR: dmem_we=1, DATAwsel=DATA_B, instr_done=1. Next state is FETCH.
- BRANCH: asel=REG, bsel=REG, alusel=SUB, ALUouten=0 so the target computed in DECODE is preserved. pcsourse=PC_ALU.
  - pcwrite = zero when funct3=000 (BEQ); pcwrite = !zero when funct3=001 (BNE).
  - Any other funct3 gives pcwrite=0, i.e. treated as not-taken.
  - instr_done=1. Next state is FETCH.
- JAL: wbsel=WB_PC, regwen=1, pcwrite=1, pcsourse=PC_ALU, instr_done=1, all in the same cycle. The link value is the pre-update PC (PCC+4). Next state is FETCH.
- ILLEGAL: all enables 0, illegal=1. The state is held until reset. instret is frozen.
- instret increments by 1 on every cycle where instr_done=1. It wraps modulo 2^CNTWIDTH.
- Latency in cycles: R/I = 4, load = 5, store = 4, branch = 3, JAL = 3.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write occurs after reset assertion.

Test Plan:
- Reset, then instr=0x002081B3 (add). States run FETCH, DECODE, EXEC_R, ALU_WB. ALU_WB has regwen=1 and wbsel=WB_ALUOUT; EXEC_R has alusel=ALU_ADD. instret goes 0->1 and instr_done pulses once.
- instr=0x40208233 (sub) gives alusel=ALU_SUB. instr=0x4030D093 (srai) gives alusel=ALU_SRA with bsel=IMM.
- instr=0x0080A283 (lw) takes 5 cycles. MEM_ADDR has immsel=IMM_L; MEM_RD has mdrwrite=1; MEM_WB has regwen=1 and wbsel=WB_MDR. instr=0x0020A223 (sw) has immsel=IMM_S and a single-cycle dmem_we=1 with DATAwsel=DATA_B.
- instr=0x00000463 (beq):
  - zero=1 in BRANCH gives pcwrite=1 and pcsourse=PC_ALU.
  - zero=0 gives pcwrite=0.
  - Repeat with bne 0x00001463 and the results invert.
- instr=0x010000EF (jal). A single cycle shows regwen=1, wbsel=WB_PC, pcwrite=1 and pcsourse=PC_ALU. DECODE has immsel=IMM_J.
- Sticky error and mid-instruction reset:
  - instr=0x00000000 goes to ILLEGAL with illegal=1 held for 20 cycles and no enables.
  - rst pulsed during MEM_RD gives state=FETCH, illegal=0, instret=0.
